mag_power_trigger: RTL
======================

Name: mag_power_trigger

Overview:
- Consumes the magnitude stream from the complex-to-magnitude stage, one `mag` sample per `mag_stb`.
- Keeps a sliding-window average of the magnitude and runs a hysteresis state machine on it.
- Produces `trigger`, a level flag that is high while signal power is present, plus single-cycle rise/fall pulses.
- Sits between magnitude estimation and the packet-detection / sync control logic.

Parameters:
- DATA_WIDTH, 16: width of `mag` and `avg_mag`.
- WIN_LOG2, 4: log2 of the averaging window; window = 2^WIN_LOG2 samples.
- LEN_WIDTH, 8: width of the minimum-run-length inputs and their counters.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  when low, all state and outputs hold; strobes are not consumed.
- clear  in  1  synchronous restart: empties the window, returns to WARMUP, outputs go to reset values.
- mag  in  DATA_WIDTH  unsigned magnitude sample.
- mag_stb  in  1  `mag` valid this cycle.
- thresh_high  in  DATA_WIDTH  rise threshold, run-time static.
- thresh_low  in  DATA_WIDTH  fall threshold, run-time static.
- min_high_len  in  LEN_WIDTH  consecutive averages above `thresh_high` required to assert `trigger`.
- min_low_len  in  LEN_WIDTH  consecutive averages below `thresh_low` required to deassert `trigger`.
- avg_mag  out  DATA_WIDTH  window average.
- avg_stb  out  1  `avg_mag` valid.
- trigger  out  1  power-present level.
- trigger_rise  out  1  one-cycle pulse when `trigger` goes 0->1.
- trigger_fall  out  1  one-cycle pulse when `trigger` goes 1->0.

Behaviour:

Reset and priority
- reset_n low: window contents, sum, counters, `avg_mag`, `avg_stb`, `trigger`, `trigger_rise`, `trigger_fall` all clear to 0; state goes to WARMUP.
- Priority: reset_n, then clear, then enable, then `mag_stb`.

Window arithmetic
- Window is a 2^WIN_LOG2-deep delay line; contents start at zero.
- Running sum is DATA_WIDTH+WIN_LOG2 bits and never overflows.
- On each accepted strobe: sum <= sum + mag - oldest; the delay line shifts.
- avg_mag = sum >> WIN_LOG2 (truncating). It is registered 1 cycle after the accepting `mag_stb`, with `avg_stb` high for that one cycle.

Warmup
- A fill counter counts accepted strobes up to 2^WIN_LOG2.
- `avg_stb` stays suppressed until the window is full. The first `avg_stb` comes 1 cycle after the 2^WIN_LOG2-th strobe.

Comparisons and run lengths
- "above" means avg > thresh_high (strict); "below" means avg < thresh_low (strict).
- The FSM evaluates only on cycles where `avg_stb` is high.
- A min length of 0 is treated as 1.
- Run counters saturate at their limit and never wrap.

FSM
- WARMUP -> IDLE when the window is full.
- IDLE: on above, cnt = 1. If min_high_len <= 1, go to ACTIVE; otherwise go to RISING.
- RISING:
  - above: cnt++; when cnt == min_high_len, go to ACTIVE.
  - not above: go to IDLE, cnt = 0.
- ACTIVE: on below, cnt = 1. If min_low_len <= 1, go to IDLE; otherwise go to FALLING.
- FALLING:
  - below: cnt++; when cnt == min_low_len, go to IDLE.
  - not below: go to ACTIVE.

Trigger outputs
- `trigger` is a registered 1 in ACTIVE and FALLING, and updates in the same cycle as the state.
- `trigger_rise` pulses for exactly 1 cycle, the cycle `trigger` first reads 1.
- `trigger_fall` pulses for exactly 1 cycle, the cycle `trigger` first reads 0.
- Total latency from the deciding `mag_stb` to a `trigger` change is 2 cycles.

Boundary conditions
- enable low on a strobe cycle: the strobe is dropped and pulses do not extend. Pulses are already 1 cycle wide, so they clear on the next enabled cycle.
- thresh_low > thresh_high is permitted; behaviour still follows the definitions above. The ACTIVE -> IDLE -> ACTIVE sequence takes at least 2 averages.
- clear or reset while ACTIVE: `trigger` drops with no `trigger_fall` pulse.

Decomposition:
- Package mag_trigger_pkg holds:
  - state enum: WARMUP, IDLE, RISING, ACTIVE, FALLING;
  - SUM_WIDTH = DATA_WIDTH + WIN_LOG2;
  - WIN_LEN = 2^WIN_LOG2.
- Sub-module mag_window_sum holds the delay line, running sum, fill counter and avg register, and outputs `avg_mag`, `avg_stb`, `full`.
- The top level holds the FSM, run counters and trigger outputs.

Test Plan:
- WIN_LOG2=2, constant mag=100 on every cycle:
  - first `avg_stb` 1 cycle after the 4th strobe, avg_mag=100;
  - no `avg_stb` earlier;
  - `trigger` stays 0 with thresh_high=200.
- thresh_high=200, thresh_low=50, min_high_len=3, min_low_len=2. Window filled with 0, then mag steps to 400:
  - averages 100, 200, 300, 400, 400;
  - 200 is not above (strict);
  - `trigger_rise` on the 3rd above average (the second 400), `trigger` stays 1 after.
- From ACTIVE, mag steps to 0:
  - averages 300, 200, 100, 0, 0;
  - `trigger_fall` after the 2nd below average (the second 0);
  - a single below sample followed by 400 returns FALLING -> ACTIVE with no pulse.
- Same setup, mag=1000 with `mag_stb` every 3rd cycle and `enable` low for 5 cycles mid-stream:
  - `avg_mag` and the FSM freeze during the enable-low cycles;
  - dropped strobes leave the sum unchanged.
- While ACTIVE, assert reset_n low asynchronously mid-cycle:
  - `trigger` is 0 immediately, with no `trigger_fall`;
  - after release, the full 4-sample warmup repeats.
- min_high_len=0 and min_low_len=0:
  - a single above average asserts `trigger`;
  - a single below average deasserts it.

Source files
------------

// File: rtl/mag_trigger_pkg.sv
// Shared constants, state encoding and width helpers for the magnitude power trigger.
package mag_trigger_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_WIN_LOG2   = 4;
  localparam int unsigned DEF_LEN_WIDTH  = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_WARMUP  = 3'd0;
  localparam state_t ST_IDLE    = 3'd1;
  localparam state_t ST_RISING  = 3'd2;
  localparam state_t ST_ACTIVE  = 3'd3;
  localparam state_t ST_FALLING = 3'd4;

  // Running-sum width: one sample plus log2(window) bits of growth, so it cannot overflow.
  function automatic int unsigned sum_width(input int unsigned data_width,
                                            input int unsigned win_log2);
    return data_width + win_log2;
  endfunction

  function automatic int unsigned win_len(input int unsigned win_log2);
    return 32'd1 << win_log2;
  endfunction

endpackage

// File: rtl/mag_window_sum.sv
// Sliding-window sum of magnitude samples with a fill counter and registered average.
module mag_window_sum
  import mag_trigger_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned WIN_LOG2   = DEF_WIN_LOG2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] mag,
  input  logic                  mag_stb,
  output logic [DATA_WIDTH-1:0] avg_mag,
  output logic                  avg_stb,
  output logic                  full
);

  localparam int unsigned SUM_W  = sum_width(DATA_WIDTH, WIN_LOG2);
  localparam int unsigned WLEN   = win_len(WIN_LOG2);
  localparam int unsigned FILL_W = WIN_LOG2 + 1;

  logic [DATA_WIDTH-1:0] line_q [WLEN];
  logic [DATA_WIDTH-1:0] line_d [WLEN];
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [DATA_WIDTH-1:0] avg_q, avg_d;
  logic                  avg_stb_q, avg_stb_d;
  logic                  full_q, full_d;

  // Enable low freezes everything, including a pending avg_stb.
  always_comb begin
    line_d    = line_q;
    sum_d     = sum_q;
    fill_d    = fill_q;
    avg_d     = avg_q;
    avg_stb_d = avg_stb_q;
    full_d    = full_q;
    if (clear) begin
      for (int i = 0; i < int'(WLEN); i++) line_d[i] = '0;
      sum_d     = '0;
      fill_d    = '0;
      avg_d     = '0;
      avg_stb_d = 1'b0;
      full_d    = 1'b0;
    end else if (enable) begin
      avg_stb_d = 1'b0;
      if (mag_stb) begin
        line_d[0] = mag;
        for (int i = 1; i < int'(WLEN); i++) line_d[i] = line_q[i-1];
        sum_d = sum_q + SUM_W'(mag) - SUM_W'(line_q[WLEN-1]);
        if (fill_q != FILL_W'(WLEN)) fill_d = fill_q + FILL_W'(1);
        full_d    = (fill_d == FILL_W'(WLEN));
        avg_d     = DATA_WIDTH'(sum_d >> WIN_LOG2);
        avg_stb_d = full_d;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(WLEN); i++) line_q[i] <= '0;
      sum_q     <= '0;
      fill_q    <= '0;
      avg_q     <= '0;
      avg_stb_q <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      line_q    <= line_d;
      sum_q     <= sum_d;
      fill_q    <= fill_d;
      avg_q     <= avg_d;
      avg_stb_q <= avg_stb_d;
      full_q    <= full_d;
    end
  end

  assign avg_mag = avg_q;
  assign avg_stb = avg_stb_q;
  assign full    = full_q;

endmodule

// File: rtl/mag_power_trigger.sv
// Hysteresis power trigger on a sliding-window magnitude average, with rise/fall pulses.
module mag_power_trigger
  import mag_trigger_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned WIN_LOG2   = DEF_WIN_LOG2,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] mag,
  input  logic                  mag_stb,
  input  logic [DATA_WIDTH-1:0] thresh_high,
  input  logic [DATA_WIDTH-1:0] thresh_low,
  input  logic [LEN_WIDTH-1:0]  min_high_len,
  input  logic [LEN_WIDTH-1:0]  min_low_len,
  output logic [DATA_WIDTH-1:0] avg_mag,
  output logic                  avg_stb,
  output logic                  trigger,
  output logic                  trigger_rise,
  output logic                  trigger_fall
);

  logic full;

  mag_window_sum #(
    .DATA_WIDTH(DATA_WIDTH),
    .WIN_LOG2  (WIN_LOG2)
  ) u_window (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (enable),
    .clear  (clear),
    .mag    (mag),
    .mag_stb(mag_stb),
    .avg_mag(avg_mag),
    .avg_stb(avg_stb),
    .full   (full)
  );

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [LEN_WIDTH-1:0] high_len, low_len;
  logic                 above, below;
  logic                 trig_q, trig_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

  // A zero run length behaves as one; the counter saturates instead of wrapping.
  assign high_len = (min_high_len == '0) ? LEN_WIDTH'(1) : min_high_len;
  assign low_len  = (min_low_len == '0) ? LEN_WIDTH'(1) : min_low_len;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + LEN_WIDTH'(1);
  assign above    = (avg_mag > thresh_high);
  assign below    = (avg_mag < thresh_low);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trig_d  = trig_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    if (clear) begin
      state_d = ST_WARMUP;
      cnt_d   = '0;
      trig_d  = 1'b0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
    end else if (enable) begin
      case (state_q)
        ST_WARMUP: if (full) state_d = ST_IDLE;
        ST_IDLE: begin
          if (avg_stb && above) begin
            cnt_d   = LEN_WIDTH'(1);
            state_d = (high_len == LEN_WIDTH'(1)) ? ST_ACTIVE : ST_RISING;
          end
        end
        ST_RISING: begin
          if (avg_stb) begin
            if (above) begin
              cnt_d = cnt_inc;
              if (cnt_inc >= high_len) state_d = ST_ACTIVE;
            end else begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end
        end
        ST_ACTIVE: begin
          if (avg_stb && below) begin
            cnt_d   = LEN_WIDTH'(1);
            state_d = (low_len == LEN_WIDTH'(1)) ? ST_IDLE : ST_FALLING;
          end
        end
        ST_FALLING: begin
          if (avg_stb) begin
            if (below) begin
              cnt_d = cnt_inc;
              if (cnt_inc >= low_len) state_d = ST_IDLE;
            end else begin
              state_d = ST_ACTIVE;
            end
          end
        end
        default: state_d = ST_WARMUP;
      endcase
      trig_d = (state_d == ST_ACTIVE) || (state_d == ST_FALLING);
      rise_d = trig_d && !trig_q;
      fall_d = !trig_d && trig_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_WARMUP;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign trigger      = trig_q;
  assign trigger_rise = rise_q;
  assign trigger_fall = fall_q;

endmodule
